vga_timing_pipeline: RTL and testbench
======================================

Name: vga_timing_pipeline

Overview:
- Parametrised VGA timing generator and output stage; successor to the fixed 640x480 VGADriver.
- Divides real100clock into a pixel clock-enable and generates horizontal/vertical counters and pixel coordinates for the drawing controller.
- Re-times the drawing controller's RGB against sync and blank, compensating a configurable drawing-pipeline latency.
- Adds a built-in checkerboard test-pattern mode and frame/line start strobes.

Parameters:
CLK_DIV, 4, real100clock cycles per pixel (>=2, even)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level
V_POL, 0, vsync active level
X_W, 10, xPixel width
Y_W, 9, yPixel width
COLOR_W, 8, bits per colour channel
PIPE, 1, drawing latency in pixel strobes (>=1; 1 = combinational drawing logic)

Ports:
real100clock  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
patternEn  in  1  1 = output internal checkerboard, ignoring rgbIn
rIn, gIn, bIn  in  COLOR_W each  colour from the drawing controller for the coordinate issued PIPE-1 strobes earlier
xPixel  out  X_W  current active-area column, 0 outside active area
yPixel  out  Y_W  current active-area line, 0 outside active area
pixStrobe  out  1  one-cycle pixel clock-enable
lineStart  out  1  one-cycle pulse when a new line begins
frameStart  out  1  one-cycle pulse when a new frame begins
hsync, vsync  out  1  sync outputs at the H_POL/V_POL active level
VGAclock  out  1  pixel clock to the DAC
VGAblanck  out  1  blank_n: 1 only during aligned active video
VGAsync  out  1  DAC composite sync_n, constant 0
VGAr, VGAg, VGAb  out  COLOR_W  aligned colour; 0 while blanked

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Internal counters are clog2(H_TOT) and clog2(V_TOT) bits wide.
- Divider: div counts 0..CLK_DIV-1 and wraps. pixStrobe is combinational, 1 when div == CLK_DIV-1. VGAclock is registered, 1 while div >= CLK_DIV/2, giving a 50% duty cycle.
- On pixStrobe:
  - hc advances and wraps at H_TOT-1.
  - On hc wrap, vc advances and wraps at V_TOT-1.
- Active region: active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - xPixel = hc[X_W-1:0] when active, else 0.
  - yPixel = vc[Y_W-1:0] when active, else 0.
- Sync windows:
  - hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- Alignment pipeline: a PIPE-stage shift register, advancing only on pixStrobe, carries {hsyncRaw, vsyncRaw, active, checker}. checker = xPixel[5]^yPixel[5], i.e. 32x32 tiles.
- Output register, updated on pixStrobe from the last pipeline stage:
  - hsync/vsync = stage values at the configured polarity.
  - VGAblanck = stage active.
  - RGB = 0 if not stage active.
  - Otherwise, RGB = all-ones or 0 per the stage checker bit if patternEn is 1, else rIn/gIn/bIn.
- Net latency: coordinates issued at strobe k appear on the outputs after strobe k+PIPE-1. Sync, blank and RGB always change on the same real100clock edge.
- lineStart/frameStart are registered. lineStart pulses for one cycle after the strobe that loads hc=0; frameStart pulses after the strobe that loads (hc,vc)=(0,0). Neither pulses on the first frame after reset.
- patternEn is sampled only at output-register updates; changing it mid-line takes effect from the next pixel.
- Reset, including mid-frame:
  - div, hc, vc = 0.
  - Pipeline stages = inactive (sync deasserted, active 0).
  - VGAr/g/b = 0, VGAblanck = 0, VGAclock = 0.
  - hsync = !H_POL, vsync = !V_POL; pulses = 0.
  - Timing restarts at (0,0) on the first cycle after reset deasserts.
- Elaboration-time checks: CLK_DIV even and >=2; PIPE>=1; X_W can hold H_ACTIVE-1; Y_W can hold V_ACTIVE-1.

Decomposition:
- Package vga_pkg:
  - Timing constants for 640x480@60 and 800x600@72.
  - Derived H_TOT/V_TOT functions and a sync-window helper function.
  - The pipeline-stage struct {hs, vs, act, chk}.
- One sub-module, vga_delay_line: a parametrised WIDTH x DEPTH shift register with clock-enable and synchronous reset value.

Test Plan:
Small config (CLK_DIV=2, H 8/2/2/2, V 4/1/1/1, PIPE=1), reset for 3 cycles, run -> pixStrobe every 2nd cycle; hsync low for hc 10..11; H_TOT=14, V_TOT=7; frameStart period 196 cycles.
Same config, rgbIn tied to xPixel -> VGAr sequence 0..7 per line, then 0 for 6 pixels; VGAblanck high exactly 8 strobes per active line.
PIPE=3, rgbIn from a 2-strobe delay model -> RGB matches coordinates; first active pixel and VGAblanck rise on the same edge.
patternEn=1, 640x480 defaults -> pixel (31,0)=0x00, (32,0)=0xFF, (32,32)=0x00; blanked pixels 0.
Assert reset mid-line at hc=5, vc=2 -> next cycle hc=vc=0, outputs at reset values, no spurious frameStart; next frameStart exactly one frame later.
Polarity sweep (H_POL=1, V_POL=1) -> hsync/vsync idle low and pulse high for 96 pixels / 2 lines respectively.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, stage record and helpers
package vga_pkg;

    // 640x480 @ 60 Hz from a 100 MHz system clock (25 MHz pixel clock)
    localparam int VGA640_CLK_DIV  = 4;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 72 Hz from a 100 MHz system clock (50 MHz pixel clock)
    localparam int SVGA800_CLK_DIV  = 2;
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;

    // Raw (polarity-free) timing attributes of one pixel as it travels to the output register
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic chk;
    } vga_stage_t;

    localparam int STAGE_W = $bits(vga_stage_t);

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_sync_window(input int pos, input int active, input int fp, input int sync);
        return (pos >= active + fp) && (pos < active + fp + sync);
    endfunction

endpackage

// File: rtl/vga_timing_pipeline_if.sv
// rtl/vga_timing_pipeline_if.sv - drawing-controller and DAC-side signal bundle of the timing pipeline
interface vga_timing_pipeline_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
);
    logic               patternEn;
    logic [COLOR_W-1:0] rIn;
    logic [COLOR_W-1:0] gIn;
    logic [COLOR_W-1:0] bIn;
    logic [X_W-1:0]     xPixel;
    logic [Y_W-1:0]     yPixel;
    logic               pixStrobe;
    logic               lineStart;
    logic               frameStart;
    logic               hsync;
    logic               vsync;
    logic               VGAclock;
    logic               VGAblanck;
    logic               VGAsync;
    logic [COLOR_W-1:0] VGAr;
    logic [COLOR_W-1:0] VGAg;
    logic [COLOR_W-1:0] VGAb;

    modport master (
        input  patternEn, rIn, gIn, bIn,
        output xPixel, yPixel, pixStrobe, lineStart, frameStart,
        output hsync, vsync, VGAclock, VGAblanck, VGAsync, VGAr, VGAg, VGAb
    );

    modport slave (
        output patternEn, rIn, gIn, bIn,
        input  xPixel, yPixel, pixStrobe, lineStart, frameStart,
        input  hsync, vsync, VGAclock, VGAblanck, VGAsync, VGAr, VGAg, VGAb
    );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - WIDTH x DEPTH enabled shift register with synchronous reset value
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("vga_delay_line: DEPTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= RST_VAL;
            end
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipeline.sv
// rtl/vga_timing_pipeline.sv - VGA timing generator with latency-compensated colour output stage
module vga_timing_pipeline
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA640_CLK_DIV,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int COLOR_W  = 8,
    parameter int PIPE     = 1
) (
    input  logic                  real100clock,
    input  logic                  reset,
    vga_timing_pipeline_if.master vga
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);
    localparam int DIV_W = $clog2(CLK_DIV);

    generate
        if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
            $error("vga_timing_pipeline: CLK_DIV must be even and >= 2");
        end
        if (PIPE < 1) begin : g_bad_pipe
            $error("vga_timing_pipeline: PIPE must be >= 1");
        end
        if ((H_ACTIVE - 1) >= (1 << X_W)) begin : g_bad_xw
            $error("vga_timing_pipeline: X_W too narrow for H_ACTIVE");
        end
        if ((V_ACTIVE - 1) >= (1 << Y_W)) begin : g_bad_yw
            $error("vga_timing_pipeline: Y_W too narrow for V_ACTIVE");
        end
    endgenerate

    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_nxt;
    logic [HC_W-1:0]    hc;
    logic [VC_W-1:0]    vc;
    logic               pix_stb;
    logic               hc_last;
    logic               vc_last;
    logic               active;
    logic [X_W-1:0]     x_pix;
    logic [Y_W-1:0]     y_pix;
    logic               vga_clk;
    logic               line_start;
    logic               frame_start;
    vga_stage_t         raw;
    vga_stage_t         aligned;
    logic               hs_q;
    logic               vs_q;
    logic               blank_q;
    logic [COLOR_W-1:0] r_q;
    logic [COLOR_W-1:0] g_q;
    logic [COLOR_W-1:0] b_q;

    assign pix_stb = (div == DIV_W'(CLK_DIV - 1));
    assign div_nxt = pix_stb ? '0 : div + DIV_W'(1);
    assign hc_last = (hc == HC_W'(H_TOT - 1));
    assign vc_last = (vc == VC_W'(V_TOT - 1));

    // Counters and the registered clock/strobe outputs; reset is the only way (0,0) is loaded
    // without a strobe, which keeps lineStart/frameStart quiet at reset release.
    always_ff @(posedge real100clock) begin
        if (reset) begin
            div         <= '0;
            hc          <= '0;
            vc          <= '0;
            vga_clk     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            vga_clk     <= (div_nxt >= DIV_W'(CLK_DIV / 2));
            line_start  <= pix_stb && hc_last;
            frame_start <= pix_stb && hc_last && vc_last;
            if (pix_stb) begin
                hc <= hc_last ? '0 : hc + HC_W'(1);
                if (hc_last) begin
                    vc <= vc_last ? '0 : vc + VC_W'(1);
                end
            end
        end
    end

    assign active = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    assign x_pix  = active ? X_W'(hc) : '0;
    assign y_pix  = active ? Y_W'(vc) : '0;

    always_comb begin
        raw     = '0;
        raw.hs  = in_sync_window(int'(hc), H_ACTIVE, H_FP, H_SYNC);
        raw.vs  = in_sync_window(int'(vc), V_ACTIVE, V_FP, V_SYNC);
        raw.act = active;
        // 32x32 tiles: bit 5 of each coordinate
        raw.chk = (|(x_pix & X_W'(32))) ^ (|(y_pix & Y_W'(32)));
    end

    // The output register is itself the last alignment stage, so only PIPE-1 extra stages
    // are needed to meet colour that the drawing logic returns PIPE-1 strobes late.
    generate
        if (PIPE > 1) begin : g_align
            vga_delay_line #(
                .WIDTH   (STAGE_W),
                .DEPTH   (PIPE - 1),
                .RST_VAL (STAGE_W'(0))
            ) u_align (
                .clk (real100clock),
                .rst (reset),
                .en  (pix_stb),
                .d   (raw),
                .q   (aligned)
            );
        end else begin : g_no_align
            assign aligned = raw;
        end
    endgenerate

    always_ff @(posedge real100clock) begin
        if (reset) begin
            hs_q    <= !H_POL;
            vs_q    <= !V_POL;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else if (pix_stb) begin
            hs_q    <= aligned.hs ? H_POL : !H_POL;
            vs_q    <= aligned.vs ? V_POL : !V_POL;
            blank_q <= aligned.act;
            if (!aligned.act) begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end else if (vga.patternEn) begin
                r_q <= {COLOR_W{aligned.chk}};
                g_q <= {COLOR_W{aligned.chk}};
                b_q <= {COLOR_W{aligned.chk}};
            end else begin
                r_q <= vga.rIn;
                g_q <= vga.gIn;
                b_q <= vga.bIn;
            end
        end
    end

    assign vga.xPixel     = x_pix;
    assign vga.yPixel     = y_pix;
    assign vga.pixStrobe  = pix_stb;
    assign vga.lineStart  = line_start;
    assign vga.frameStart = frame_start;
    assign vga.hsync      = hs_q;
    assign vga.vsync      = vs_q;
    assign vga.VGAclock   = vga_clk;
    assign vga.VGAblanck  = blank_q;
    assign vga.VGAsync    = 1'b0;
    assign vga.VGAr       = r_q;
    assign vga.VGAg       = g_q;
    assign vga.VGAb       = b_q;

endmodule

// File: tb/tb_vga_timing_pipeline.sv
// tb/tb_vga_timing_pipeline.sv - directed checks of small, pipelined, pattern and polarity configurations
module tb_vga_timing_pipeline;

    typedef struct {
        int         hc;
        logic [7:0] r;
        logic       blank;
        logic       hs;
    } line_vec_t;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] rgb;
        logic       blank;
    } pat_vec_t;

    typedef struct {
        int   p;
        logic hs;
        logic vs;
    } pol_vec_t;

    localparam int C_END = 51270;

    logic clk = 1'b0;
    logic rst;
    logic rst0;
    logic pat2;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    line_vec_t lv [14];
    logic      vs_tbl [7];
    pat_vec_t  pv [5];
    pol_vec_t  qv [8];

    always #5 clk = ~clk;

    vga_timing_pipeline_if #(.X_W(10), .Y_W(9), .COLOR_W(8)) if0 ();
    vga_timing_pipeline_if #(.X_W(10), .Y_W(9), .COLOR_W(8)) if1 ();
    vga_timing_pipeline_if #(.X_W(10), .Y_W(9), .COLOR_W(8)) if2 ();
    vga_timing_pipeline_if #(.X_W(10), .Y_W(9), .COLOR_W(8)) if3 ();

    vga_timing_pipeline #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(1)
    ) u0 (.real100clock(clk), .reset(rst0), .vga(if0.master));

    vga_timing_pipeline #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(3)
    ) u1 (.real100clock(clk), .reset(rst), .vga(if1.master));

    vga_timing_pipeline #(.CLK_DIV(2), .PIPE(1)) u2 (.real100clock(clk), .reset(rst), .vga(if2.master));

    vga_timing_pipeline #(
        .CLK_DIV(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE(1)
    ) u3 (.real100clock(clk), .reset(rst), .vga(if3.master));

    // Drawing controller models
    logic [9:0] m1x, m2x;
    logic [8:0] m1y, m2y;

    always @(posedge clk) begin
        if (rst) begin
            m1x <= '0; m2x <= '0; m1y <= '0; m2y <= '0;
        end else if (if1.pixStrobe) begin
            m1x <= if1.xPixel; m1y <= if1.yPixel;
            m2x <= m1x;        m2y <= m1y;
        end
    end

    assign if0.patternEn = 1'b0;
    assign if0.rIn       = 8'(if0.xPixel);
    assign if0.gIn       = 8'h00;
    assign if0.bIn       = 8'h00;
    assign if1.patternEn = 1'b0;
    assign if1.rIn       = 8'(m2x) + 8'd1;
    assign if1.gIn       = 8'(m2y);
    assign if1.bIn       = 8'h00;
    assign if2.patternEn = pat2;
    assign if2.rIn       = 8'h5A;
    assign if2.gIn       = 8'h5A;
    assign if2.bIn       = 8'h5A;
    assign if3.patternEn = 1'b0;
    assign if3.rIn       = 8'h00;
    assign if3.gIn       = 8'h00;
    assign if3.bIn       = 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected small-config output for frame-order pixel p (p < 0: still at reset values)
    function automatic void exp_pix(input int p, output logic [7:0] r, output logic b,
                                    output logic hs, output logic vs, output int vc);
        r = 8'h00; b = 1'b0; hs = 1'b1; vs = 1'b1; vc = 0;
        if (p >= 0) begin
            vc = (p / 14) % 7;
            for (int i = 0; i < 14; i++) begin
                if (lv[i].hc == p % 14) begin
                    hs = lv[i].hs;
                    if (vc < 4) begin
                        r = lv[i].r;
                        b = lv[i].blank;
                    end
                end
            end
            vs = vs_tbl[vc];
        end
    endfunction

    initial begin
        logic [7:0] er;
        logic       eb, ehs, evs;
        int         evc, p, hcc, vcc, bl_cnt, hs_cnt, vs_cnt, first_fs, first_ls;
        bit         hit;

        lv[0]  = '{0,  8'd0, 1'b1, 1'b1};
        lv[1]  = '{1,  8'd1, 1'b1, 1'b1};
        lv[2]  = '{2,  8'd2, 1'b1, 1'b1};
        lv[3]  = '{3,  8'd3, 1'b1, 1'b1};
        lv[4]  = '{4,  8'd4, 1'b1, 1'b1};
        lv[5]  = '{5,  8'd5, 1'b1, 1'b1};
        lv[6]  = '{6,  8'd6, 1'b1, 1'b1};
        lv[7]  = '{7,  8'd7, 1'b1, 1'b1};
        lv[8]  = '{8,  8'd0, 1'b0, 1'b1};
        lv[9]  = '{9,  8'd0, 1'b0, 1'b1};
        lv[10] = '{10, 8'd0, 1'b0, 1'b0};
        lv[11] = '{11, 8'd0, 1'b0, 1'b0};
        lv[12] = '{12, 8'd0, 1'b0, 1'b1};
        lv[13] = '{13, 8'd0, 1'b0, 1'b1};
        vs_tbl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        pv[0] = '{31,  0,  8'h00, 1'b1};
        pv[1] = '{32,  0,  8'hFF, 1'b1};
        pv[2] = '{32,  32, 8'h00, 1'b1};
        pv[3] = '{63,  1,  8'hFF, 1'b1};
        pv[4] = '{700, 0,  8'h00, 1'b0};

        qv[0] = '{655,  1'b0, 1'b0};
        qv[1] = '{656,  1'b1, 1'b0};
        qv[2] = '{751,  1'b1, 1'b0};
        qv[3] = '{752,  1'b0, 1'b0};
        qv[4] = '{3999, 1'b0, 1'b0};
        qv[5] = '{4000, 1'b0, 1'b1};
        qv[6] = '{5599, 1'b0, 1'b1};
        qv[7] = '{5600, 1'b0, 1'b0};

        rst = 1'b1; rst0 = 1'b1; pat2 = 1'b1;
        repeat (3) tick();

        chk("rst0_blank", if0.VGAblanck, 0);
        chk("rst0_r", if0.VGAr, 0);
        chk("rst0_hsync", if0.hsync, 1);
        chk("rst0_vsync", if0.vsync, 1);
        chk("rst0_vgaclk", if0.VGAclock, 0);
        chk("rst0_strobe", if0.pixStrobe, 0);
        chk("rst0_sync_n", if0.VGAsync, 0);
        chk("rst1_blank", if1.VGAblanck, 0);
        chk("rst2_r", if2.VGAr, 0);
        chk("rst3_hsync", if3.hsync, 0);
        chk("rst3_vsync", if3.vsync, 0);

        rst = 1'b0; rst0 = 1'b0;
        bl_cnt = 0; hs_cnt = 0; vs_cnt = 0;

        for (int c = 1; c <= C_END; c++) begin
            tick();
            cyc = c;
            if (c == 201) pat2 = 1'b0;
            if (c == 203) pat2 = 1'b1;

            if (c <= 420) begin
                p = c / 2 - 1;
                exp_pix(p, er, eb, ehs, evs, evc);
                chk("d0_r", if0.VGAr, er);
                chk("d0_blank", if0.VGAblanck, eb);
                chk("d0_hsync", if0.hsync, ehs);
                chk("d0_vsync", if0.vsync, evs);
                chk("d0_strobe", if0.pixStrobe, c % 2);
                chk("d0_vgaclk", if0.VGAclock, c % 2);
                chk("d0_linestart", if0.lineStart, (c % 28) == 0);
                chk("d0_framestart", if0.frameStart, (c % 196) == 0);
                hcc = (c / 2) % 14;
                vcc = (c / 28) % 7;
                chk("d0_xpixel", if0.xPixel, (hcc < 8 && vcc < 4) ? hcc : 0);
                chk("d0_ypixel", if0.yPixel, (hcc < 8 && vcc < 4) ? vcc : 0);
                if (c % 2 == 0 && p >= 0) begin
                    bl_cnt += int'(if0.VGAblanck);
                    if (p % 14 == 13) begin
                        chk("d0_blank_per_line", bl_cnt, (evc < 4) ? 8 : 0);
                        bl_cnt = 0;
                    end
                end

                exp_pix(c / 2 - 3, er, eb, ehs, evs, evc);
                chk("d1_blank", if1.VGAblanck, eb);
                chk("d1_r", if1.VGAr, eb ? er + 8'd1 : 8'd0);
                chk("d1_g", if1.VGAg, eb ? evc : 0);
                chk("d1_hsync", if1.hsync, ehs);
                chk("d1_vsync", if1.vsync, evs);
            end

            for (int i = 0; i < 5; i++) begin
                if (c == 2 * (pv[i].y * 800 + pv[i].x + 1)) begin
                    chk("d2_blank", if2.VGAblanck, pv[i].blank);
                    chk("d2_r", if2.VGAr, pv[i].rgb);
                    chk("d2_g", if2.VGAg, pv[i].rgb);
                    chk("d2_b", if2.VGAb, pv[i].rgb);
                end
            end
            if (c == 200) chk("d2_pat_before", if2.VGAr, 8'hFF);
            if (c == 202) chk("d2_pat_off", if2.VGAr, 8'h5A);
            if (c == 204) chk("d2_pat_back", if2.VGAr, 8'hFF);

            for (int i = 0; i < 8; i++) begin
                if (c == 2 * (qv[i].p + 1)) begin
                    chk("d3_hsync", if3.hsync, qv[i].hs);
                    chk("d3_vsync", if3.vsync, qv[i].vs);
                end
            end
            if (c % 2 == 0 && c <= 12800) begin
                hs_cnt += int'(if3.hsync);
                vs_cnt += int'(if3.vsync);
            end
            if (c == 12800) begin
                chk("d3_hsync_strobes", hs_cnt, 768);
                chk("d3_vsync_strobes", vs_cnt, 1600);
            end
        end

        // Mid-frame reset of the small configuration at hc=5, vc=2
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            tick();
            if (if0.xPixel == 10'd5 && if0.yPixel == 9'd2) hit = 1'b1;
        end
        chk("midrst_reach", hit, 1);
        rst0 = 1'b1;
        tick();
        chk("midrst_x", if0.xPixel, 0);
        chk("midrst_y", if0.yPixel, 0);
        chk("midrst_blank", if0.VGAblanck, 0);
        chk("midrst_r", if0.VGAr, 0);
        chk("midrst_hsync", if0.hsync, 1);
        chk("midrst_vsync", if0.vsync, 1);
        chk("midrst_vgaclk", if0.VGAclock, 0);
        chk("midrst_fs", if0.frameStart, 0);
        chk("midrst_ls", if0.lineStart, 0);
        rst0 = 1'b0;
        first_fs = 0; first_ls = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (if0.frameStart && first_fs == 0) first_fs = k;
            if (if0.lineStart && first_ls == 0) first_ls = k;
        end
        chk("midrst_first_framestart", first_fs, 196);
        chk("midrst_first_linestart", first_ls, 28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
